stream_demux_1to4: RTL and testbench

STREAM_DEMUX_1TO4 -- requirements
Module: stream_demux_1to4

---
 rtl/stream_demux_1to4.sv | 108 ++++++++++
 tb/tb_stream_demux_1to4.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/stream_demux_1to4.sv
// 1-to-4 stream demultiplexer. Each output channel has its own DEPTH-entry FIFO.
// Define STREAM_DEMUX_BYPASS_EN so a word can pass straight through an empty channel in the same cycle.
module stream_demux_1to4 #(
  parameter int size  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [size-1:0] data_i,
  input  logic [1:0]      select_i,
  input  logic            valid_i,
  output logic            ready_o,
  output logic [size-1:0] data0_o,
  output logic [size-1:0] data1_o,
  output logic [size-1:0] data2_o,
  output logic [size-1:0] data3_o,
  output logic [3:0]      valid_o,
  input  logic [3:0]      ready_i
);

  // Handshake: a word moves on a rising clk_i edge only when its valid and ready are both high.
  // ready_o depends only on select_i and on the fill level of that channel.
  // Each valid_o[n] depends only on channel n's fill level, plus valid_i/select_i when bypass is enabled.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [size-1:0] mem [4][DEPTH];
  logic [AW-1:0]   wr_ptr [4];
  logic [AW-1:0]   rd_ptr [4];
  logic [CW-1:0]   cnt    [4];

  logic [3:0]      full;
  logic [3:0]      empty;
  logic [3:0]      push;
  logic [3:0]      pop;
  logic [3:0]      byp;
  logic [size-1:0] head     [4];
  logic [size-1:0] out_data [4];
  logic            fire;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      full[n]  = (cnt[n] == CW'(DEPTH));
      empty[n] = (cnt[n] == '0);
      head[n]  = mem[n][rd_ptr[n]];
    end
  end

  assign ready_o = ~full[select_i];
  assign fire    = valid_i & ready_o;

  always_comb begin
    byp     = '0;
    push    = '0;
    pop     = '0;
    valid_o = '0;
    for (int n = 0; n < 4; n++) begin
      out_data[n] = head[n];
`ifdef STREAM_DEMUX_BYPASS_EN
      // An empty channel presents the upstream word directly; if taken, it never touches the FIFO.
      if (empty[n] && (select_i == 2'(n))) begin
        valid_o[n]  = valid_i;
        out_data[n] = data_i;
        byp[n]      = valid_i & ready_i[n];
      end else begin
        valid_o[n]  = ~empty[n];
      end
`else
      valid_o[n] = ~empty[n];
`endif
      push[n] = fire && (select_i == 2'(n)) && !byp[n];
      pop[n]  = ~empty[n] & ready_i[n];
    end
  end

  assign data0_o = out_data[0];
  assign data1_o = out_data[1];
  assign data2_o = out_data[2];
  assign data3_o = out_data[3];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < 4; n++) begin
        wr_ptr[n] <= '0;
        rd_ptr[n] <= '0;
        cnt[n]    <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (push[n]) wr_ptr[n] <= wr_ptr[n] + AW'(1);
        if (pop[n])  rd_ptr[n] <= rd_ptr[n] + AW'(1);
        case ({push[n], pop[n]})
          2'b10:   cnt[n] <= cnt[n] + CW'(1);
          2'b01:   cnt[n] <= cnt[n] - CW'(1);
          default: cnt[n] <= cnt[n];
        endcase
      end
    end
  end

  // Storage has no reset; stale entries are never visible because valid_o follows the counts.
  always_ff @(posedge clk_i) begin
    for (int n = 0; n < 4; n++) begin
      if (push[n]) mem[n][wr_ptr[n]] <= data_i;
    end
  end

endmodule

// File: tb/tb_stream_demux_1to4.sv
// Testbench for stream_demux_1to4: vector table, directed corner sequences, and random traffic.
// Random traffic is checked against per-channel queue models.
module tb_stream_demux_1to4;

  localparam int DEPTH = 2;
`ifdef STREAM_DEMUX_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] data_i;
  logic [1:0]  select_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data0_o, data1_o, data2_o, data3_o;
  logic [3:0]  valid_o;
  logic [3:0]  ready_i;
  logic [31:0] dout [4];

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q [4][$];
  logic [31:0] rx_q [$];

  stream_demux_1to4 #(.size(32), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .data_i(data_i), .select_i(select_i),
    .valid_i(valid_i), .ready_o(ready_o), .data0_o(data0_o), .data1_o(data1_o),
    .data2_o(data2_o), .data3_o(data3_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  assign dout[0] = data0_o;
  assign dout[1] = data1_o;
  assign dout[2] = data2_o;
  assign dout[3] = data3_o;

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int n = 0; n < 4; n++) exp_q[n].delete();
  endtask

  task automatic do_reset();
    valid_i = 1'b0; select_i = 2'd0; data_i = '0; ready_i = '0;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clear_model();
  endtask

  // driver: one clock with model-predicted outputs checked at the falling edge
  task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d,
                       input logic [3:0] r, output logic acc);
    logic        exp_rdy;
    logic [3:0]  emp;
    logic [3:0]  ev;
    logic [31:0] ed [4];
    valid_i = v; select_i = s; data_i = d; ready_i = r;
    @(negedge clk_i);
    exp_rdy = (exp_q[s].size() < DEPTH);
    for (int n = 0; n < 4; n++) begin
      emp[n] = (exp_q[n].size() == 0);
      ev[n]  = !emp[n] || (BYP && v && (s == 2'(n)));
      ed[n]  = emp[n] ? d : exp_q[n][0];
    end
    chk("ready_o", 32'(ready_o), 32'(exp_rdy));
    chk("valid_o", 32'(valid_o), 32'(ev));
    for (int n = 0; n < 4; n++)
      if (ev[n]) chk($sformatf("data%0d_o", n), dout[n], ed[n]);
    if (valid_o[2] && r[2]) rx_q.push_back(data2_o);
    @(posedge clk_i);
    for (int n = 0; n < 4; n++)
      if (!emp[n] && r[n]) void'(exp_q[n].pop_front());
    acc = v && exp_rdy;
    if (acc && !(BYP && emp[s] && r[s])) exp_q[s].push_back(d);
    #1;
  endtask

  typedef struct {
    logic             v;
    logic [1:0]       s;
    logic [31:0]      d;
    logic [3:0]       r;
    logic             do_rst;
    logic             exp_rdy;
    logic [3:0]       exp_v;
    logic [3:0]       exp_v_byp;
    logic [3:0][31:0] exp_d;
  } vec_t;

  function automatic vec_t mk(logic v, logic [1:0] s, logic [31:0] d, logic do_rst,
                              logic er, logic [3:0] ev, logic [3:0] evb, logic [3:0][31:0] ed);
    vec_t t;
    t.v = v; t.s = s; t.d = d; t.r = 4'b0000; t.do_rst = do_rst;
    t.exp_rdy = er; t.exp_v = ev; t.exp_v_byp = evb; t.exp_d = ed;
    return t;
  endfunction

  vec_t vt [10];

  initial begin
    logic [3:0][31:0] rd_a;
    logic [3:0][31:0] rd_b;
    logic acc;
    logic [3:0] ev;
    int sent;

    rst_i = 1'b1; valid_i = 1'b0; select_i = 2'd0; data_i = '0; ready_i = '0;
    #1;
    chk("reset valid_o", 32'(valid_o), 32'h0);
    chk("reset ready_o", 32'(ready_o), 32'h1);
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;

    // routing, then fill/stall/isolation: ready_i held at 0000 throughout
    rd_a = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    rd_b = {32'hC0, 32'h0, 32'hB0, 32'h0};
    vt[0] = mk(1, 0, 32'hA0, 0, 1, 4'b0000, 4'b0001, rd_a);
    vt[1] = mk(1, 1, 32'hA1, 0, 1, 4'b0001, 4'b0011, rd_a);
    vt[2] = mk(1, 2, 32'hA2, 0, 1, 4'b0011, 4'b0111, rd_a);
    vt[3] = mk(1, 3, 32'hA3, 0, 1, 4'b0111, 4'b1111, rd_a);
    vt[4] = mk(0, 0, 32'h0,  0, 1, 4'b1111, 4'b1111, rd_a);
    vt[5] = mk(1, 1, 32'hB0, 1, 1, 4'b0000, 4'b0010, rd_b);
    vt[6] = mk(1, 1, 32'hB1, 0, 1, 4'b0010, 4'b0010, rd_b);
    vt[7] = mk(1, 1, 32'hB2, 0, 0, 4'b0010, 4'b0010, rd_b);
    vt[8] = mk(1, 3, 32'hC0, 0, 1, 4'b0010, 4'b1010, rd_b);
    vt[9] = mk(0, 1, 32'h0,  0, 0, 4'b1010, 4'b1010, rd_b);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].do_rst) do_reset();
      valid_i = vt[i].v; select_i = vt[i].s; data_i = vt[i].d; ready_i = vt[i].r;
      @(negedge clk_i);
      ev = BYP ? vt[i].exp_v_byp : vt[i].exp_v;
      chk($sformatf("vec%0d ready_o", i), 32'(ready_o), 32'(vt[i].exp_rdy));
      chk($sformatf("vec%0d valid_o", i), 32'(valid_o), 32'(ev));
      for (int n = 0; n < 4; n++)
        if (ev[n]) chk($sformatf("vec%0d data%0d_o", i, n), dout[n], vt[i].exp_d[n]);
      @(posedge clk_i);
      #1;
    end

    // asynchronous reset with channel 2 holding two words
    do_reset();
    cycle(1, 2, 32'h21, 4'b0000, acc);
    cycle(1, 2, 32'h22, 4'b0000, acc);
    valid_i = 1'b0; select_i = 2'd2;
    #2;
    chk("pre-reset ready_o", 32'(ready_o), 32'h0);
    chk("pre-reset valid_o", 32'(valid_o), 32'b0100);
    rst_i = 1'b1;
    #1;
    chk("async reset valid_o", 32'(valid_o), 32'h0);
    chk("async reset ready_o", 32'(ready_o), 32'h1);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    clear_model();
    cycle(1, 2, 32'h33, 4'b0000, acc);
    cycle(0, 2, 32'h0, 4'b0000, acc);

    // simultaneous push and pop on channel 0 holding one word
    do_reset();
    cycle(1, 0, 32'h11, 4'b0000, acc);
    cycle(1, 0, 32'h55, 4'b0001, acc);
    chk("push/pop valid0", 32'(valid_o[0]), 32'h1);
    chk("push/pop data0", data0_o, 32'h55);
    cycle(0, 0, 32'h0, 4'b0001, acc);
    cycle(0, 0, 32'h0, 4'b0000, acc);
    chk("push/pop drained", 32'(valid_o[0]), 32'h0);

    // wrap and order on channel 2 with toggling ready
    do_reset();
    rx_q.delete();
    sent = 0;
    for (int c = 0; c < 60 && (sent < 10 || exp_q[2].size() != 0); c++) begin
      cycle(sent < 10, 2, 32'(sent), (c % 2 == 1) ? 4'b0100 : 4'b0000, acc);
      if (acc) sent++;
    end
    chk("ch2 words sent", 32'(sent), 32'd10);
    chk("ch2 words received", 32'(rx_q.size()), 32'd10);
    for (int i = 0; i < rx_q.size(); i++) chk($sformatf("ch2 order %0d", i), rx_q[i], 32'(i));

    // bypass timing on an empty channel with downstream ready
    do_reset();
    valid_i = 1'b1; select_i = 2'd3; data_i = 32'h77; ready_i = 4'b1000;
    #2;
    chk("bypass same-cycle valid3", 32'(valid_o[3]), BYP ? 32'h1 : 32'h0);
    if (valid_o[3]) chk("bypass same-cycle data3", data3_o, 32'h77);
    @(posedge clk_i);
    #1;
    valid_i = 1'b0;
    #2;
    chk("bypass next-cycle valid3", 32'(valid_o[3]), BYP ? 32'h0 : 32'h1);
    if (!BYP) chk("bypass next-cycle data3", data3_o, 32'h77);
    @(posedge clk_i);
    #1;

    // random traffic against the queue model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom,
            4'($urandom_range(0, 15) & $urandom_range(0, 15)), acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
